// File: rtl/coco_wb_pkg.sv
// Shared types and constants for the register-file writeback slice.
// Included by coco_wb_fifo and coco_wb_writeback.
package coco_wb_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/coco_wb_fifo.sv
// Small power-of-two FIFO for long-latency writeback requests.
// Pointers wrap naturally; count distinguishes full from empty.
module coco_wb_fifo
    import coco_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              push,
    input  wb_req_t           wdata,
    input  logic              pop,
    output wb_req_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    wb_req_t mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge Clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/coco_wb_writeback.sv
// Register-file write port arbiter: pipe results win, long results queue.
// Define COCO_WB_FWD_EN to add Fwd1_Hit/Fwd2_Hit bypass-hit outputs.
module coco_wb_writeback
    import coco_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Pipe_Valid,
    input  logic [REG_AW-1:0] Pipe_RD,
    input  logic [DATA_W-1:0] Pipe_Data,
    input  logic              Long_Issue,
    input  logic [REG_AW-1:0] Long_IssueRD,
    input  logic              Long_Valid,
    output logic              Long_Ready,
    input  logic [REG_AW-1:0] Long_RD,
    input  logic [DATA_W-1:0] Long_Data,
    output logic [REG_AW-1:0] RD,
    output logic              RegWrite,
    output logic [DATA_W-1:0] WData,
    input  logic [REG_AW-1:0] Q_RS1,
    input  logic [REG_AW-1:0] Q_RS2,
    output logic              Busy1,
    output logic              Busy2,
`ifdef COCO_WB_FWD_EN
    output logic              Fwd1_Hit,
    output logic              Fwd2_Hit,
`endif
    output logic [$clog2(DEPTH):0] Fifo_Count
);

    wb_req_t     head;
    wb_req_t     long_req;
    logic        full;
    logic        empty;
    logic        pipe_wr;
    logic        pop;
    logic        push;
    logic [31:0] pending;
    logic [31:0] pending_nxt;

    assign pipe_wr    = Pipe_Valid && (Pipe_RD != REG_ZERO);
    assign pop        = !pipe_wr && !empty;
    assign Long_Ready = !full && !Reset;
    assign push       = Long_Valid && Long_Ready;
    assign long_req   = '{rd: Long_RD, data: Long_Data};

    coco_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (push),
        .wdata (long_req),
        .pop   (pop),
        .head  (head),
        .count (Fifo_Count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RD       <= REG_ZERO;
            RegWrite <= 1'b0;
            WData    <= '0;
        end else begin
            unique case (1'b1)
                pipe_wr: begin
                    RD       <= Pipe_RD;
                    WData    <= Pipe_Data;
                    RegWrite <= 1'b1;
                end
                pop: begin
                    RD       <= head.rd;
                    WData    <= head.data;
                    RegWrite <= 1'b1;
                end
                default: RegWrite <= 1'b0;
            endcase
        end
    end

    // Set is applied after clear so a same-cycle reissue stays pending.
    always_comb begin
        pending_nxt = pending;
        if (pop) pending_nxt[head.rd] = 1'b0;
        if (Long_Issue && (Long_IssueRD != REG_ZERO))
            pending_nxt[Long_IssueRD] = 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) pending <= '0;
        else       pending <= pending_nxt;
    end

    assign Busy1 = pending[Q_RS1];
    assign Busy2 = pending[Q_RS2];

`ifdef COCO_WB_FWD_EN
    assign Fwd1_Hit = RegWrite && (RD != REG_ZERO) && (RD == Q_RS1);
    assign Fwd2_Hit = RegWrite && (RD != REG_ZERO) && (RD == Q_RS2);
`endif

endmodule

// File: tb/tb_coco_wb_writeback.sv
// Scoreboard bench for coco_wb_writeback: expected writes are queued by
// the stimulus and popped by a negedge monitor on every RegWrite.
module tb_coco_wb_writeback;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Pipe_Valid;
    logic [4:0]  Pipe_RD;
    logic [31:0] Pipe_Data;
    logic        Long_Issue;
    logic [4:0]  Long_IssueRD;
    logic        Long_Valid;
    logic        Long_Ready;
    logic [4:0]  Long_RD;
    logic [31:0] Long_Data;
    logic [4:0]  RD;
    logic        RegWrite;
    logic [31:0] WData;
    logic [4:0]  Q_RS1;
    logic [4:0]  Q_RS2;
    logic        Busy1;
    logic        Busy2;
`ifdef COCO_WB_FWD_EN
    logic        Fwd1_Hit;
    logic        Fwd2_Hit;
`endif
    logic [$clog2(DEPTH):0] Fifo_Count;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    coco_wb_writeback #(.DEPTH(DEPTH)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Pipe_Valid   (Pipe_Valid),
        .Pipe_RD      (Pipe_RD),
        .Pipe_Data    (Pipe_Data),
        .Long_Issue   (Long_Issue),
        .Long_IssueRD (Long_IssueRD),
        .Long_Valid   (Long_Valid),
        .Long_Ready   (Long_Ready),
        .Long_RD      (Long_RD),
        .Long_Data    (Long_Data),
        .RD           (RD),
        .RegWrite     (RegWrite),
        .WData        (WData),
        .Q_RS1        (Q_RS1),
        .Q_RS2        (Q_RS2),
        .Busy1        (Busy1),
        .Busy2        (Busy2),
`ifdef COCO_WB_FWD_EN
        .Fwd1_Hit     (Fwd1_Hit),
        .Fwd2_Hit     (Fwd2_Hit),
`endif
        .Fifo_Count   (Fifo_Count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin : monitor
        exp_t e;
        if (!Reset && RegWrite) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: RD=%0d WData=%h, none expected",
                         RD, WData);
            end else begin
                e = exp_q.pop_front();
                chk("wr_rd", 32'(RD), 32'(e.rd));
                chk("wr_data", WData, e.data);
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Pipe_Valid = 1'b0;
        Long_Valid = 1'b0;
        Long_Issue = 1'b0;
    endtask

    task automatic pipe(input logic [4:0] r, input logic [31:0] d);
        Pipe_Valid = 1'b1;
        Pipe_RD    = r;
        Pipe_Data  = d;
        if (r != 5'd0) exp_q.push_back('{rd: r, data: d});
    endtask

    task automatic long_in(input logic [4:0] r, input logic [31:0] d);
        Long_Valid = 1'b1;
        Long_RD    = r;
        Long_Data  = d;
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
        exp_q.push_back('{rd: r, data: d});
    endtask

    // Issues a long op, first confirming the target is not already pending.
    task automatic issue(input logic [4:0] r);
        Q_RS1 = r;
        #1;
        chk("issue_not_pending", 32'(Busy1), 32'd0);
        Long_Issue   = 1'b1;
        Long_IssueRD = r;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        Reset = 1'b0;
        idle();
        Pipe_RD = '0; Pipe_Data = '0;
        Long_IssueRD = '0; Long_RD = '0; Long_Data = '0;
        Q_RS1 = 5'd1; Q_RS2 = 5'd2;
        #1 Reset = 1'b1;
        step();
        step();
        @(negedge Clk);
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_rd", 32'(RD), 32'd0);
        chk("rst_wdata", WData, 32'd0);
        chk("rst_count", 32'(Fifo_Count), 32'd0);
        chk("rst_ready", 32'(Long_Ready), 32'd0);
        step();
        Reset = 1'b0;
        #1;
        chk("ready_after_rst", 32'(Long_Ready), 32'd1);

        // Single pipe write: one cycle of RegWrite.
        pipe(5'd3, 32'h0000_1234);
        step();
        idle();
        @(negedge Clk);
        chk("pipe_we", 32'(RegWrite), 32'd1);
        step();
        @(negedge Clk);
        chk("pipe_we_drop", 32'(RegWrite), 32'd0);

        // Long op to r8: busy until the write appears.
        issue(5'd8);
        step();
        Long_Issue = 1'b0;
        @(negedge Clk);
        chk("busy_set", 32'(Busy1), 32'd1);
        long_in(5'd8, 32'hCAFE_F00D);
        expect_wr(5'd8, 32'hCAFE_F00D);
        step();
        idle();
        @(negedge Clk);
        chk("long_lat_we0", 32'(RegWrite), 32'd0);
        chk("long_lat_busy", 32'(Busy1), 32'd1);
        chk("long_cnt1", 32'(Fifo_Count), 32'd1);
        step();
        @(negedge Clk);
        chk("long_we", 32'(RegWrite), 32'd1);
        chk("busy_clear", 32'(Busy1), 32'd0);
        chk("long_cnt0", 32'(Fifo_Count), 32'd0);
        step();

        // Long results wait behind a busy pipe, then drain in order.
        pipe(5'd10, 32'h0000_00A0);
        long_in(5'd4, 32'hAAAA_0004);
        step();
        pipe(5'd11, 32'h0000_00B0);
        long_in(5'd5, 32'hBBBB_0005);
        step();
        pipe(5'd12, 32'h0000_00C0);
        Long_Valid = 1'b0;
        @(negedge Clk);
        chk("starve_cnt2a", 32'(Fifo_Count), 32'd2);
        step();
        idle();
        expect_wr(5'd4, 32'hAAAA_0004);
        expect_wr(5'd5, 32'hBBBB_0005);
        @(negedge Clk);
        chk("starve_cnt2b", 32'(Fifo_Count), 32'd2);
        step();
        @(negedge Clk);
        chk("drain_cnt1", 32'(Fifo_Count), 32'd1);
        step();
        @(negedge Clk);
        chk("drain_cnt0", 32'(Fifo_Count), 32'd0);
        step();

        // Fill to DEPTH under a saturated pipe.
        for (int i = 0; i < DEPTH; i++) begin
            pipe(5'(20 + i), 32'h0000_2000 + i);
            long_in(5'(16 + i), 32'h1600_0000 + i);
            step();
        end
        pipe(5'd24, 32'h0000_2004);
        long_in(5'd30, 32'h3000_0030);
        @(negedge Clk);
        chk("full_cnt", 32'(Fifo_Count), 32'd4);
        chk("full_ready", 32'(Long_Ready), 32'd0);
        step();
        Pipe_Valid = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            expect_wr(5'(16 + i), 32'h1600_0000 + i);
        expect_wr(5'd30, 32'h3000_0030);
        @(negedge Clk);
        chk("full_cnt_hold", 32'(Fifo_Count), 32'd4);
        chk("full_ready_hold", 32'(Long_Ready), 32'd0);
        step();
        @(negedge Clk);
        chk("pop_cnt3", 32'(Fifo_Count), 32'd3);
        chk("pop_ready", 32'(Long_Ready), 32'd1);
        step();
        Long_Valid = 1'b0;
        @(negedge Clk);
        chk("pushpop_cnt", 32'(Fifo_Count), 32'd3);
        repeat (3) step();
        @(negedge Clk);
        chk("full_drained", 32'(Fifo_Count), 32'd0);
        step();

        // Pipe result to r0 does not block the FIFO.
        long_in(5'd6, 32'h6666_0006);
        expect_wr(5'd6, 32'h6666_0006);
        step();
        Long_Valid = 1'b0;
        Pipe_Valid = 1'b1;
        Pipe_RD    = 5'd0;
        Pipe_Data  = 32'hDEAD_BEEF;
        step();
        idle();
        @(negedge Clk);
        chk("r0_pop_we", 32'(RegWrite), 32'd1);
        chk("r0_pop_rd", 32'(RD), 32'd6);
        chk("r0_pop_cnt", 32'(Fifo_Count), 32'd0);
        step();

        // Asynchronous reset with queued entries and pending bits.
        issue(5'd21);
        step();
        issue(5'd22);
        step();
        Long_Issue = 1'b0;
        pipe(5'd25, 32'h0000_0025);
        long_in(5'd21, 32'h2121_2121);
        step();
        pipe(5'd26, 32'h0000_0026);
        long_in(5'd22, 32'h2222_2222);
        step();
        pipe(5'd27, 32'h0000_0027);
        long_in(5'd23, 32'h2323_2323);
        step();
        idle();
        Q_RS1 = 5'd21;
        Q_RS2 = 5'd22;
        @(negedge Clk);
        chk("pre_rst_cnt", 32'(Fifo_Count), 32'd3);
        chk("pre_rst_busy1", 32'(Busy1), 32'd1);
        chk("pre_rst_busy2", 32'(Busy2), 32'd1);
        chk("pre_rst_we", 32'(RegWrite), 32'd1);
        #1 Reset = 1'b1;
        #1;
        chk("arst_cnt", 32'(Fifo_Count), 32'd0);
        chk("arst_busy1", 32'(Busy1), 32'd0);
        chk("arst_busy2", 32'(Busy2), 32'd0);
        chk("arst_we", 32'(RegWrite), 32'd0);
        chk("arst_ready", 32'(Long_Ready), 32'd0);
        step();
        step();
        Reset = 1'b0;

`ifdef COCO_WB_FWD_EN
        pipe(5'd9, 32'h0000_9999);
        Q_RS1 = 5'd7;
        Q_RS2 = 5'd9;
        step();
        idle();
        @(negedge Clk);
        chk("fwd2_hit", 32'(Fwd2_Hit), 32'd1);
        chk("fwd1_miss", 32'(Fwd1_Hit), 32'd0);
        step();
        @(negedge Clk);
        chk("fwd2_drop", 32'(Fwd2_Hit), 32'd0);
`endif

        repeat (3) step();
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
